gcd_controller: RTL and testbench

//  Control FSM for the repeated-subtraction GCD datapath. Drives the ldA, ldB,
//  sel1, sel2 and sel_in inputs and consumes the gt/lt/eq comparator outputs.

---
 rtl/gcd_controller.sv | 122 ++++++++++++
 tb/tb_gcd_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
// Module      : gcd_controller
// Description : Control FSM for a repeated-subtraction GCD datapath with a
//               start/done handshake and an iteration limit.
// Revision    : 1.0
// ============================================================================
module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             req_a,
    output logic             req_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD_A  = 3'd1;
    localparam logic [2:0] c_ST_LOAD_B  = 3'd2;
    localparam logic [2:0] c_ST_COMPUTE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_ERR     = 3'd5;

    localparam logic [CNT_W-1:0] c_MAX_ITER = CNT_W'(MAX_ITER);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_iter_cnt;
    logic             w_one_hot;
    logic             w_sub;

    // A corrupted comparator (none or several flags) must abort, never spin.
    assign w_one_hot = ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) ||
                       ({gt, lt, eq} == 3'b001);
    assign w_sub     = (r_state == c_ST_COMPUTE) && w_one_hot && !eq &&
                       (r_iter_cnt != c_MAX_ITER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_iter_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_ST_IDLE) && start) begin
                r_iter_cnt <= '0;
            end else if (w_sub) begin
                r_iter_cnt <= r_iter_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:    if (start) w_next_state = c_ST_LOAD_A;
            c_ST_LOAD_A:  w_next_state = c_ST_LOAD_B;
            c_ST_LOAD_B:  w_next_state = c_ST_COMPUTE;
            c_ST_COMPUTE: begin
                if (!w_one_hot)                      w_next_state = c_ST_ERR;
                else if (eq)                         w_next_state = c_ST_DONE;
                else if (r_iter_cnt == c_MAX_ITER)   w_next_state = c_ST_ERR;
            end
            c_ST_DONE:    w_next_state = c_ST_IDLE;
            c_ST_ERR:     w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ldA    = 1'b0;
        ldB    = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b0;
        sel_in = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        case (r_state)
            c_ST_LOAD_A: begin
                sel_in = 1'b1;
                ldA    = 1'b1;
                req_a  = 1'b1;
            end
            c_ST_LOAD_B: begin
                sel_in = 1'b1;
                ldB    = 1'b1;
                req_b  = 1'b1;
            end
            c_ST_COMPUTE: begin
                if (w_sub && gt) begin
                    sel2 = 1'b1;
                    ldA  = 1'b1;
                end else if (w_sub && lt) begin
                    sel1 = 1'b1;
                    ldB  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B) ||
                      (r_state == c_ST_COMPUTE);
    assign done     = (r_state == c_ST_DONE) || (r_state == c_ST_ERR);
    assign err      = (r_state == c_ST_ERR);
    assign iter_cnt = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gcd_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_controller
// Description : Bench for gcd_controller with a behavioural datapath and a
//               plain-arithmetic GCD reference model.
// Revision    : 1.0
// ============================================================================
module tb_gcd_controller;

    localparam int MAX_ITER = 10;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             gt, lt, eq;
    logic             ldA, ldB, sel1, sel2, sel_in, req_a, req_b;
    logic             busy, done, err;
    logic [CNT_W-1:0] iter_cnt;

    logic [15:0] opa, opb;
    logic [15:0] ra, rb;
    logic [15:0] data_in, dp_x, dp_y, dp_sub;
    logic        force_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_controller #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .gt(gt), .lt(lt), .eq(eq),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .req_a(req_a), .req_b(req_b),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    // Datapath: two registers, two muxes, a subtractor and a comparator.
    assign data_in = req_a ? opa : (req_b ? opb : 16'd0);
    assign dp_x    = sel1 ? rb : ra;
    assign dp_y    = sel2 ? rb : ra;
    assign dp_sub  = dp_x - dp_y;
    assign gt      = !force_zero && (ra > rb);
    assign lt      = !force_zero && (ra < rb);
    assign eq      = !force_zero && (ra == rb);

    always @(posedge clk) begin
        if (ldA) ra <= sel_in ? data_in : dp_sub;
        if (ldB) rb <= sel_in ? data_in : dp_sub;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_gcd(input int a_in, input int b_in,
                                    output int res, output int n, output bit e);
        int a = a_in;
        int b = b_in;
        n = 0;
        e = 1'b0;
        while (a != b) begin
            if (n == MAX_ITER) begin
                e = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        res = a;
    endfunction

    // Launches one GCD; poke>0 pulses start in that cycle to prove it is ignored.
    task automatic run(input int a, input int b, input int poke);
        int  exp_res, exp_n, c;
        bit  exp_err, got_done, busy_ok;
        ref_gcd(a, b, exp_res, exp_n, exp_err);
        opa = 16'(a);
        opb = 16'(b);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        c        = 1;
        got_done = 1'b0;
        busy_ok  = 1'b1;
        while (c <= MAX_ITER + 12) begin
            if (c == 1) check("load_a", {28'd0, req_a, ldA, sel_in, req_b}, 32'b1110);
            if (c == 2) check("load_b", {28'd0, req_a, ldB, sel_in, req_b}, 32'b0111);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            start = (poke != 0 && c == poke);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!got_done) begin
            check("timeout", 0, 1);
        end else begin
            check("done_cycle", c, 4 + exp_n);
            check("err", {31'd0, err}, {31'd0, exp_err});
            check("iter_cnt", {16'd0, iter_cnt}, exp_n);
            check("busy_run", {31'd0, busy_ok}, 1);
            check("busy_at_done", {31'd0, busy}, 0);
            if (!exp_err) check("result", {16'd0, ra}, exp_res);
        end
        @(negedge clk);
        check("idle_after", {29'd0, busy, done, err}, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        force_zero = 1'b0;
        opa        = '0;
        opb        = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {22'd0, ldA, ldB, sel1, sel2, sel_in, req_a, req_b,
                             busy, done, err}, 0);
        check("reset_cnt", {16'd0, iter_cnt}, 0);
        rst = 1'b0;

        run(12, 8, 0);
        run(7, 7, 0);
        run(0, 5, 0);
        run(0, 0, 0);
        run(5, 0, 0);
        run(11, 1, 0);
        run(12, 1, 0);
        run(9, 2, 4);

        for (int i = 0; i < 20; i++) begin
            run(int'($urandom_range(0, 24)), int'($urandom_range(0, 24)), 0);
        end

        // Synchronous reset in the middle of COMPUTE aborts without done.
        opa = 16'd0;
        opb = 16'd5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", {25'd0, ldA, ldB, sel1, sel_in, busy, done, err}, 0);
        check("rst_mid_cnt", {16'd0, iter_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Comparator with no flag set forces an error exit.
        opa = 16'd20;
        opb = 16'd3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        force_zero = 1'b1;
        @(negedge clk);
        check("bad_cmp_done", {30'd0, done, err}, 32'b11);
        force_zero = 1'b0;
        @(negedge clk);
        check("bad_cmp_idle", {30'd0, busy, done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
